// File: rtl/sram_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_adapter_pkg
// Brief    : Shared request-type encodings and response-entry layout helpers
//            for the SRAM val/rdy adapter and its response queue.
// Revision : 1.0 - initial release
// ============================================================================
package sram_adapter_pkg;

    // Request/response type encodings
    localparam logic REQ_TYPE_READ  = 1'b0;
    localparam logic REQ_TYPE_WRITE = 1'b1;

    // Response entry layout: {type, data}. Data occupies the low bits,
    // the type flag sits directly above the data field.
    localparam int RESP_DATA_LSB = 0;

    // Total width of one queued response entry
    function automatic int resp_entry_nbits(input int data_nbits);
        return 1 + data_nbits;
    endfunction

    // Bit position of the type flag inside a response entry
    function automatic int resp_type_bit(input int data_nbits);
        return RESP_DATA_LSB + data_nbits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_adapter_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : sram_adapter_resp_queue
// Brief    : Response FIFO for the SRAM adapter. Arbitrary (non power of two)
//            depth, pointers wrap modulo depth, occupancy exported so the
//            adapter can compute its request-ready from registered state.
// Revision : 1.0 - initial release
// ============================================================================
module sram_adapter_resp_queue
    import sram_adapter_pkg::*;
#(
    parameter  int p_entry_nbits = 33,
    parameter  int p_depth       = 3,
    localparam int c_count_nbits = $clog2(p_depth + 1)
) (
    input  logic                     clk,
    input  logic                     reset,      // synchronous, active-low
    input  logic                     enq_val,
    input  logic [p_entry_nbits-1:0] enq_data,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [p_entry_nbits-1:0] deq_data,
    output logic [c_count_nbits-1:0] count
);

    localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_depth - 1);

    logic [p_entry_nbits-1:0] r_mem [p_depth];
    logic [c_ptr_nbits-1:0]   r_wr_ptr;
    logic [c_ptr_nbits-1:0]   r_rd_ptr;
    logic [c_count_nbits-1:0] r_count;
    logic                     w_enq;
    logic                     w_deq;

    // Advance a pointer, wrapping at the last physical entry
    function automatic logic [c_ptr_nbits-1:0] next_ptr(input logic [c_ptr_nbits-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_nbits'(1);
    endfunction

    // The adapter only enqueues when space is guaranteed, so no full check here
    assign w_enq    = enq_val;
    assign deq_val  = (r_count != '0);
    assign w_deq    = deq_val && deq_rdy;
    assign deq_data = r_mem[r_rd_ptr];
    assign count    = r_count;

    // Entry storage: written on enqueue, no reset needed
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    // Pointers and occupancy; simultaneous enq/deq leaves count unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_count_nbits'(1);
                2'b01:   r_count <= r_count - c_count_nbits'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_resp_adapter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_resp_adapter
// Brief    : Val/rdy front end for a synchronous 1rw SRAM. Drives the SRAM in
//            the request-fire cycle, captures the result one cycle later and
//            buffers it in a response queue so downstream backpressure never
//            loses read data.
//            Optional build macro SRAM_ADAPTER_RD_BYPASS_EN: when the queue
//            is empty the returning response is presented combinationally
//            (1-cycle latency) instead of going through the queue (2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_resp_adapter
    import sram_adapter_pkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    parameter  int p_queue_depth = 3,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,              // synchronous, active-low

    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_type,
    input  logic [c_addr_nbits-1:0]  req_addr,
    input  logic [p_data_nbits-1:0]  req_data,
    input  logic [c_data_nbytes-1:0] req_byte_en,

    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_type,
    output logic [p_data_nbits-1:0]  resp_data,

    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    input  logic [p_data_nbits-1:0]  sram_read_data,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data
);

    localparam int c_entry_nbits = resp_entry_nbits(p_data_nbits);
    localparam int c_type_bit    = resp_type_bit(p_data_nbits);
    localparam int c_count_nbits = $clog2(p_queue_depth + 1);

    // Goes high one cycle after reset is released; keeps req_rdy low for
    // the first cycle out of reset.
    logic                     r_live;
    // In-flight request: the SRAM access issued last cycle whose result
    // (read data or write acknowledge) is due this cycle.
    logic                     r_inflight_val;
    logic                     r_inflight_type;

    logic                     w_req_fire;
    logic                     w_req_rdy;
    logic [p_data_nbits-1:0]  w_inflight_data;
    logic [c_entry_nbits-1:0] w_inflight_entry;
    logic                     w_q_enq_val;
    logic                     w_q_deq_val;
    logic                     w_q_deq_rdy;
    logic [c_entry_nbits-1:0] w_q_deq_data;
    logic [c_count_nbits-1:0] w_q_count;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    // Accept only when the queue can hold every response already owed,
    // including the one in flight. Registered state only: no path from
    // resp_rdy into req_rdy.
    assign w_req_rdy  = reset && r_live &&
                        ((32'(w_q_count) + 32'(r_inflight_val)) < p_queue_depth);
    assign req_rdy    = w_req_rdy;
    assign w_req_fire = req_val && w_req_rdy;

    // SRAM port is driven straight from the firing request
    assign sram_read_en       = w_req_fire && (req_type == REQ_TYPE_READ);
    assign sram_read_addr     = req_addr;
    assign sram_write_en      = w_req_fire && (req_type == REQ_TYPE_WRITE);
    assign sram_write_addr    = req_addr;
    assign sram_write_data    = req_data;
    assign sram_write_byte_en = req_byte_en;

    // Track the request issued this cycle so its result is captured next cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_live          <= 1'b0;
            r_inflight_val  <= 1'b0;
            r_inflight_type <= REQ_TYPE_READ;
        end else begin
            r_live         <= 1'b1;
            r_inflight_val <= w_req_fire;
            if (w_req_fire) begin
                r_inflight_type <= req_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture: sram_read_data is only meaningful in the cycle
    // after a read fire, so writes substitute zero instead of sampling it.
    // ------------------------------------------------------------------
    assign w_inflight_data  = (r_inflight_type == REQ_TYPE_READ) ? sram_read_data : '0;
    assign w_inflight_entry = {r_inflight_type, w_inflight_data};

    sram_adapter_resp_queue #(
        .p_entry_nbits (c_entry_nbits),
        .p_depth       (p_queue_depth)
    ) u_resp_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (w_q_enq_val),
        .enq_data (w_inflight_entry),
        .deq_val  (w_q_deq_val),
        .deq_rdy  (w_q_deq_rdy),
        .deq_data (w_q_deq_data),
        .count    (w_q_count)
    );

    // The queue only dequeues when it holds something, so a bypassed
    // response never pops a queue entry.
    assign w_q_deq_rdy = reset && resp_rdy;

`ifdef SRAM_ADAPTER_RD_BYPASS_EN
    logic w_bypass;

    // Empty queue: present the returning response directly; enqueue it
    // only if the consumer is not ready this cycle.
    assign w_bypass    = r_inflight_val && !w_q_deq_val;
    assign resp_val    = reset && (w_q_deq_val || w_bypass);
    assign resp_type   = w_bypass ? r_inflight_type : w_q_deq_data[c_type_bit];
    assign resp_data   = w_bypass ? w_inflight_data
                                  : w_q_deq_data[RESP_DATA_LSB +: p_data_nbits];
    assign w_q_enq_val = r_inflight_val && !(w_bypass && resp_rdy);
`else
    // Every response is staged through the queue
    assign resp_val    = reset && w_q_deq_val;
    assign resp_type   = w_q_deq_data[c_type_bit];
    assign resp_data   = w_q_deq_data[RESP_DATA_LSB +: p_data_nbits];
    assign w_q_enq_val = r_inflight_val;
`endif

    // Protocol checks while out of reset: known handshakes, in-range address
    always_ff @(posedge clk) begin
        if (reset) begin
            a_req_val_known  : assert (!$isunknown(req_val));
            a_resp_rdy_known : assert (!$isunknown(resp_rdy));
            a_addr_in_range  : assert (!w_req_fire || (32'(req_addr) < p_num_entries));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_resp_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_resp_adapter
// Brief    : Self-checking bench for sram_req_resp_adapter with a behavioural
//            SRAM and a transaction-level reference of owed responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_resp_adapter;

`ifdef SRAM_ADAPTER_RD_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val, req_rdy, req_type;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_byte_en;
    logic        resp_val, resp_rdy, resp_type;
    logic [31:0] resp_data;
    logic        sram_read_en, sram_write_en;
    logic [7:0]  sram_read_addr, sram_write_addr;
    logic [31:0] sram_read_data, sram_write_data;
    logic [3:0]  sram_write_byte_en;

    sram_req_resp_adapter dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .req_byte_en(req_byte_en),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
        .resp_data(resp_data),
        .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
        .sram_read_data(sram_read_data),
        .sram_write_en(sram_write_en), .sram_write_byte_en(sram_write_byte_en),
        .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic        typ;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        log_q[$];
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    logic        mem_loaded = 1'b0;
    logic        prev_reset = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return {8'hC0, 8'(i), 8'h5A, 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: 1-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (sram_write_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_write_byte_en[b])
                    sram_mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
        end
        sram_read_data <= sram_read_en ? sram_mem[sram_read_addr] : 32'hBAD0_BAD0;
    end

    // Reference: list of owed responses, each visible LAT cycles after its fire
    always @(negedge clk) begin
        logic live;
        logic fire;
        rsp_t e;
        live = reset && prev_reset;
        chk("req_rdy", req_rdy, live && (exp_q.size() < DEPTH));
        chk("resp_val", resp_val,
            live && (exp_q.size() > 0) && ((exp_q.size() > 0) ? (cyc - exp_q[0].cyc >= LAT) : 1'b0));
        if (resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_type", resp_type, e.typ);
                chk("resp_data", resp_data, e.data);
                log_q.push_back('{typ: resp_type, data: resp_data, cyc: cyc});
            end
        end
        if (!reset) exp_q.delete();
        fire = req_val && req_rdy;
        if (fire && !req_type) begin
            chk("sram_read_en", sram_read_en, 1);
            chk("sram_write_en_on_rd", sram_write_en, 0);
            chk("sram_read_addr", sram_read_addr, req_addr);
            exp_q.push_back('{typ: 1'b0, data: ref_mem[req_addr], cyc: cyc});
        end else if (fire) begin
            chk("sram_write_en", sram_write_en, 1);
            chk("sram_read_en_on_wr", sram_read_en, 0);
            chk("sram_write_addr", sram_write_addr, req_addr);
            chk("sram_write_data", sram_write_data, req_data);
            chk("sram_write_byte_en", sram_write_byte_en, req_byte_en);
            for (int b = 0; b < 4; b++)
                if (req_byte_en[b]) ref_mem[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
            exp_q.push_back('{typ: 1'b1, data: 32'h0, cyc: cyc});
        end else begin
            chk("sram_en_idle", {sram_read_en, sram_write_en}, 2'b00);
        end
        prev_reset = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, hold until accepted (bounded), report fire cycle and stalls
    task automatic do_req(input logic typ, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int fcyc, output int stalls);
        bit ok = 0;
        stalls = 0;
        fcyc = 0;
        req_val = 1'b1; req_type = typ; req_addr = addr; req_data = data; req_byte_en = be;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_rdy) begin
                fcyc = cyc;
                ok = 1;
                break;
            end
            stalls++;
        end
        if (!ok) chk("req_accept_timeout", 0, 1);
        step();
        req_val = 1'b0;
    endtask

    task automatic wait_log(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (log_q.size() >= n) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) chk("resp_timeout", log_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, st, stalls, base, acc;
        bit ok;
        reset = 1'b0; req_val = 1'b0; req_type = 1'b0; req_addr = '0;
        req_data = '0; req_byte_en = '0; resp_rdy = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_cycle_after_reset", req_rdy, 0);
        chk("resp_val_cycle_after_reset", resp_val, 0);
        step();
        @(negedge clk);
        chk("rdy_live", req_rdy, 1);
        step();

        // Eight back-to-back reads of 0..7
        base = log_q.size();
        stalls = 0;
        for (int a = 0; a < 8; a++) begin
            do_req(1'b0, 8'(a), 32'h0, 4'h0, f0, st);
            stalls += st;
        end
        chk("b2b_no_stall", stalls, 0);
        wait_log(base + 8, ok);
        if (ok) begin
            for (int k = 1; k < 8; k++)
                chk("b2b_spacing", log_q[base+k].cyc - log_q[base+k-1].cyc, 1);
            chk("b2b_addr3_data", log_q[base+3].data, 32'hC0035A03);
        end

        // Write then read address 5
        base = log_q.size();
        do_req(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, f0, st);
        do_req(1'b0, 8'd5, 32'h0, 4'h0, f1, st);
        wait_log(base + 2, ok);
        if (ok) begin
            chk("wr_resp_type", log_q[base].typ, 1);
            chk("wr_resp_data", log_q[base].data, 32'h0);
            chk("wr_resp_latency", log_q[base].cyc - f0, LAT);
            chk("rd_resp_type", log_q[base+1].typ, 0);
            chk("rd_resp_data", log_q[base+1].data, 32'hDEADBEEF);
        end

        // Partial byte-enable merge at address 9
        base = log_q.size();
        do_req(1'b1, 8'd9, 32'h11223344, 4'hF, f0, st);
        do_req(1'b1, 8'd9, 32'hAABBCCDD, 4'b0101, f0, st);
        do_req(1'b0, 8'd9, 32'h0, 4'h0, f0, st);
        wait_log(base + 3, ok);
        if (ok) chk("byte_en_merge", log_q[base+2].data, 32'h11BB33DD);

        // Backpressure: only DEPTH requests accepted while resp_rdy is low
        base = log_q.size();
        resp_rdy = 1'b0;
        req_val = 1'b1; req_type = 1'b0; req_addr = 8'd20;
        acc = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_rdy) begin
                acc++;
                step();
                req_addr = req_addr + 8'd1;
            end else begin
                step();
            end
        end
        req_val = 1'b0;
        chk("bp_accepted", acc, 3);
        chk("bp_no_resp_yet", log_q.size() - base, 0);
        resp_rdy = 1'b1;
        wait_log(base + 3, ok);
        if (ok) begin
            chk("bp_resp0", log_q[base].data, 32'hC0145A14);
            chk("bp_resp1", log_q[base+1].data, 32'hC0155A15);
            chk("bp_resp2", log_q[base+2].data, 32'hC0165A16);
        end
        do_req(1'b0, 8'd23, 32'h0, 4'h0, f0, st);
        wait_log(base + 4, ok);
        if (ok) chk("bp_resume_data", log_q[base+3].data, 32'hC0175A17);

        // Reset with two responses queued and one in flight
        repeat (3) step();
        base = log_q.size();
        resp_rdy = 1'b0;
        do_req(1'b0, 8'd30, 32'h0, 4'h0, f0, st);
        do_req(1'b0, 8'd31, 32'h0, 4'h0, f0, st);
        do_req(1'b0, 8'd32, 32'h0, 4'h0, f0, st);
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        resp_rdy = 1'b1;
        repeat (12) step();
        chk("reset_drops_all", log_q.size() - base, 0);
        @(negedge clk);
        chk("rdy_after_mid_reset", req_rdy, 1);
        step();

        // Single read on an idle adapter: latency pin
        base = log_q.size();
        do_req(1'b0, 8'd40, 32'h0, 4'h0, f0, st);
        wait_log(base + 1, ok);
        if (ok) begin
            chk("idle_rd_latency", log_q[base].cyc - f0, LAT);
            chk("idle_rd_data", log_q[base].data, 32'hC0285A28);
        end

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_req_resp_adapter.md
Name: sram_req_resp_adapter

Overview:
- Val/rdy front end for a synchronous 1rw SRAM: accepts read/write memory requests, drives the SRAM port, and returns responses through a val/rdy interface.
- Sits directly upstream of the synchronous SRAM and absorbs its 1-cycle read latency.
- Buffers responses so that downstream backpressure never loses SRAM read data.

Parameters:
- p_data_nbits, 32, data width (multiple of 8)
- p_num_entries, 256, SRAM depth
- p_queue_depth, 3, response queue entries (min 2; 3 gives full throughput)
- c_addr_nbits, $clog2(p_num_entries), local only, not set from outside
- c_data_nbytes, (p_data_nbits+7)/8, local only, not set from outside

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_type  in  1  0=read, 1=write
- req_addr  in  c_addr_nbits  word address
- req_data  in  p_data_nbits  write data
- req_byte_en  in  c_data_nbytes  write byte enables
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_type  out  1  echoes req_type
- resp_data  out  p_data_nbits  read data; 0 for writes
- sram_read_en  out  1  to SRAM
- sram_read_addr  out  c_addr_nbits  to SRAM
- sram_read_data  in  p_data_nbits  from SRAM, valid the cycle after sram_read_en
- sram_write_en  out  1  to SRAM
- sram_write_byte_en  out  c_data_nbytes  to SRAM
- sram_write_addr  out  c_addr_nbits  to SRAM
- sram_write_data  out  p_data_nbits  to SRAM

Behaviour:
- Clock is clk. Reset is `reset`, synchronous, active-low: when reset==0 at a clk edge, the queue is emptied and the in-flight flag is cleared.
- During reset and the cycle after: req_rdy=0, resp_val=0, sram_read_en=0, sram_write_en=0.
- Request fire = req_val && req_rdy.
- SRAM drive (combinational, same cycle as fire):
  - read fire: sram_read_en=1, sram_read_addr=req_addr.
  - write fire: sram_write_en=1, address, data and byte_en passed through.
  - Never both enables in one cycle. Both enables are 0 when there is no fire.
- In-flight register, set on fire, cleared the next cycle. Holds type, and the write-ack flag.
- Cycle after fire: enqueue {type, data}. Data is sram_read_data for reads, 0 for writes.
  - sram_read_data is never sampled except in the cycle after a read fire, because it is X otherwise.
- req_rdy = (count + inflight) < p_queue_depth.
  - Depends on registered state only; no comb path from resp_rdy.
- resp_val = queue not empty. resp_type and resp_data come from the head entry.
- Dequeue on resp_val && resp_rdy.
- Simultaneous enqueue and dequeue: count unchanged. Works when full (enqueue is guaranteed to fit by the rdy rule).
- Latency: fire at t gives resp_val at t+2 when the queue was empty. Sustained 1 req/cycle when resp_rdy is held high.
- Ordering: strict FIFO.
- Queue pointers wrap modulo p_queue_depth; non-power-of-2 depths are supported.
- Address must be < p_num_entries on fire. A VC_ASSERT checks this under reset==1, along with not-X on req_val and resp_rdy.
- Reset asserted mid-transaction drops the in-flight request and all queued responses; none is ever presented.

Optional Feature:
- Macro: SRAM_ADAPTER_RD_BYPASS_EN.
- Defined: when the queue is empty and an in-flight response returns, it is presented combinationally.
  - resp_val=1 at t+1, with data straight from sram_read_data, or 0 for a write.
  - If resp_rdy=1 it is consumed without an enqueue; otherwise it is enqueued.
  - Latency is 1 cycle.
- Undefined: all responses pass through the queue; latency is 2 cycles.

Decomposition:
- Package sram_adapter_pkg:
  - REQ_TYPE_READ=1'b0, REQ_TYPE_WRITE=1'b1
  - response-entry width constant (1+p_data_nbits) and its field offsets
- Sub-module sram_adapter_resp_queue:
  - parameterised-depth FIFO
  - enq_val, deq_val/deq_rdy, count output
  - the adapter top holds only the in-flight register, the rdy logic and the SRAM drive.

Test Plan:
- Write addr 5, data 0xDEADBEEF, byte_en 4'b1111, then read addr 5 -> write resp (type 1, data 0) at t+2, then read resp data 0xDEADBEEF.
- Write 0x11223344 to addr 9, then write 0xAABBCCDD with byte_en 4'b0101, then read addr 9 -> 0x11BB33DD.
- 8 back-to-back reads of addrs 0..7 with resp_rdy=1 -> req_rdy stays 1, responses arrive in order, one per cycle.
- resp_rdy=0 with req_val=1 -> exactly 3 requests accepted, then req_rdy=0. Raising resp_rdy -> 3 responses in order, then acceptance resumes.
- Reset driven low while 2 responses are queued and 1 is in flight -> resp_val=0 after reset, and no stale response appears later.
- Under SRAM_ADAPTER_RD_BYPASS_EN: read fire at t on an empty queue with resp_rdy=1 -> resp_val=1 at t+1 with the correct data.
